// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect types: BRESP codes, B-channel FSM states
// and the round-robin priority helper used by the arbiters.
package axi_ic_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  // Slot searched at position off, starting just after last.
  function automatic int rr_index(
    input int last,
    input int off,
    input int n
  );
    return (last + 1 + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin arbiter: i_req, i_last in;
// one-hot o_gnt, binary o_idx and o_any (some request) out.
module rr_arbiter_core
  import axi_ic_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[rr_index(int'(i_last), k, N)]) begin
        o_any = 1'b1;
        o_gnt[rr_index(int'(i_last), k, N)] = 1'b1;
        o_idx = IW'(rr_index(int'(i_last), k, N));
      end
    end
  end

endmodule

// File: rtl/br_resp_arbiter.sv
// AXI B-channel scheduler: round-robin over slave B sources, routes by
// BID to a registered master B port; tracks outstanding writes/errors.
module br_resp_arbiter
  import axi_ic_pkg::*;
#(
  parameter int Num_Of_Masters  = 2,
  parameter int Num_Of_Slaves   = 2,
  parameter int Master_ID_Width = 1,
  parameter int Ost_Width       = 4
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [Num_Of_Slaves*Master_ID_Width-1:0] M_AXI_BID,
  input  logic [Num_Of_Slaves*2-1:0]               M_AXI_bresp,
  input  logic [Num_Of_Slaves-1:0]                 M_AXI_bvalid,
  output logic [Num_Of_Slaves-1:0]                 M_AXI_bready,
  output logic [Num_Of_Masters*2-1:0]              S_AXI_bresp,
  output logic [Num_Of_Masters-1:0]                S_AXI_bvalid,
  input  logic [Num_Of_Masters-1:0]                S_AXI_bready,
  input  logic [Num_Of_Masters-1:0]                AW_Issue,
  output logic [Num_Of_Masters-1:0]                Outstanding_Zero,
  output logic                                     Err_Bad_BID,
  output logic                                     Err_Unexpected,
  output logic                                     Err_Ost_Overflow
);

  localparam int SW = (Num_Of_Slaves > 1) ? $clog2(Num_Of_Slaves) : 1;
  localparam int IW = Master_ID_Width;

  state_t r_state, w_next;

  logic [Num_Of_Slaves-1:0]  w_gnt;
  logic [SW-1:0]             w_idx;
  logic                      w_any;
  logic [SW-1:0]             r_last;
  logic [IW-1:0]             w_bid, r_bid;
  logic [1:0]                w_resp, r_resp;
  logic                      w_bad, w_take, r_bad;
  logic [Num_Of_Masters-1:0] w_sel, w_dec;
  logic [Num_Of_Masters-1:0] w_ovf, w_unx;
  logic [Num_Of_Masters-1:0] r_zero;
  logic                      r_err_unx, r_err_ovf;

  logic [Ost_Width-1:0] r_cnt  [Num_Of_Masters];
  logic [Ost_Width-1:0] w_cnt  [Num_Of_Masters];

  rr_arbiter_core #(
    .N  (Num_Of_Slaves),
    .IW (SW)
  ) u_rr (
    .i_req  (M_AXI_bvalid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_bid  = M_AXI_BID[w_idx*IW +: IW];
  assign w_resp = M_AXI_bresp[w_idx*2 +: 2];
  assign w_bad  = int'(w_bid) >= Num_Of_Masters;
  assign w_take = (r_state == IDLE) && w_any;

  always_comb begin
    w_next       = r_state;
    M_AXI_bready = '0;
    unique case (r_state)
      IDLE: begin
        M_AXI_bready = w_gnt;
        if (w_any && !w_bad) w_next = RESP;
      end
      RESP: begin
        if (|(w_sel & S_AXI_bready)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    S_AXI_bresp = '0;
    for (int m = 0; m < Num_Of_Masters; m++) begin
      w_sel[m] = (r_state == RESP) && (r_bid == IW'(m));
      if (w_sel[m]) S_AXI_bresp[m*2 +: 2] = r_resp;
    end
  end

  assign S_AXI_bvalid = w_sel;
  assign w_dec        = w_sel & S_AXI_bready;

  // Inc+dec in the same cycle cancels; saturate both ends.
  always_comb begin
    for (int m = 0; m < Num_Of_Masters; m++) begin
      w_cnt[m] = r_cnt[m];
      w_ovf[m] = 1'b0;
      w_unx[m] = 1'b0;
      unique case ({AW_Issue[m], w_dec[m]})
        2'b10: begin
          if (&r_cnt[m]) w_ovf[m] = 1'b1;
          else           w_cnt[m] = r_cnt[m] + 1'b1;
        end
        2'b01: begin
          if (r_cnt[m] == '0) w_unx[m] = 1'b1;
          else                w_cnt[m] = r_cnt[m] - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= IDLE;
      r_last    <= SW'(Num_Of_Slaves - 1);
      r_bid     <= '0;
      r_resp    <= BRESP_OKAY;
      r_bad     <= 1'b0;
      r_zero    <= '1;
      r_err_unx <= 1'b0;
      r_err_ovf <= 1'b0;
      for (int m = 0; m < Num_Of_Masters; m++) r_cnt[m] <= '0;
    end else begin
      r_state   <= w_next;
      r_bad     <= w_take && w_bad;
      r_err_unx <= r_err_unx | (|w_unx);
      r_err_ovf <= r_err_ovf | (|w_ovf);
      if (w_take) begin
        r_last <= w_idx;
        r_bid  <= w_bid;
        r_resp <= w_resp;
      end
      for (int m = 0; m < Num_Of_Masters; m++) begin
        r_cnt[m]  <= w_cnt[m];
        r_zero[m] <= (w_cnt[m] == '0);
      end
    end
  end

  assign Outstanding_Zero = r_zero;
  assign Err_Bad_BID      = r_bad;
  assign Err_Unexpected   = r_err_unx;
  assign Err_Ost_Overflow = r_err_ovf;

endmodule

// File: tb/tb_br_resp_arbiter.sv
// Bench for br_resp_arbiter: queued slave sources, per-master
// expected-response scoreboard, scenario tasks.
module tb_br_resp_arbiter;

  localparam int NM = 3;
  localparam int NS = 2;
  localparam int IW = 2;

  typedef struct {
    logic [1:0] bid;
    logic [1:0] resp;
  } item_t;

  logic          clk;
  logic          rst_n;
  logic [3:0]    m_bid;
  logic [3:0]    m_resp;
  logic [1:0]    m_valid;
  logic [1:0]    m_ready;
  logic [5:0]    s_resp;
  logic [2:0]    s_valid;
  logic [2:0]    s_ready;
  logic [2:0]    aw;
  logic [2:0]    oz;
  logic          e_bad, e_unx, e_ovf;

  int checks = 0;
  int errors = 0;

  item_t      sq0[$];
  item_t      sq1[$];
  logic [1:0] exp0[$];
  logic [1:0] exp1[$];
  logic [1:0] exp2[$];
  int         got_s[$];
  int         got_m[$];

  br_resp_arbiter #(
    .Num_Of_Masters  (NM),
    .Num_Of_Slaves   (NS),
    .Master_ID_Width (IW),
    .Ost_Width       (4)
  ) dut (
    .ACLK             (clk),
    .ARESETN          (rst_n),
    .M_AXI_BID        (m_bid),
    .M_AXI_bresp      (m_resp),
    .M_AXI_bvalid     (m_valid),
    .M_AXI_bready     (m_ready),
    .S_AXI_bresp      (s_resp),
    .S_AXI_bvalid     (s_valid),
    .S_AXI_bready     (s_ready),
    .AW_Issue         (aw),
    .Outstanding_Zero (oz),
    .Err_Bad_BID      (e_bad),
    .Err_Unexpected   (e_unx),
    .Err_Ost_Overflow (e_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave sources: present queue heads, pop on handshake.
  initial begin
    logic [1:0] hs;
    m_valid = '0;
    m_bid   = '0;
    m_resp  = '0;
    forever begin
      @(negedge clk);
      hs = m_valid & m_ready;
      @(posedge clk);
      #2;
      if (hs[0] && sq0.size() > 0) void'(sq0.pop_front());
      if (hs[1] && sq1.size() > 0) void'(sq1.pop_front());
      m_valid[0] = sq0.size() > 0;
      m_valid[1] = sq1.size() > 0;
      if (m_valid[0]) begin
        m_bid[1:0]  = sq0[0].bid;
        m_resp[1:0] = sq0[0].resp;
      end
      if (m_valid[1]) begin
        m_bid[3:2]  = sq1[0].bid;
        m_resp[3:2] = sq1[0].resp;
      end
    end
  end

  // Monitor: scoreboard on master handshakes, bready sanity.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((m_ready & ~m_valid) !== 2'b00) begin
        errors++;
        $display("FAIL bready_no_valid: ready=%b valid=%b",
                 m_ready, m_valid);
      end
      for (int i = 0; i < NS; i++)
        if (m_valid[i] && m_ready[i]) got_s.push_back(i);
      for (int m = 0; m < NM; m++) begin
        if (s_valid[m] && s_ready[m]) begin
          logic [1:0] e;
          int         n;
          got_m.push_back(m);
          n = (m == 0) ? exp0.size() :
              (m == 1) ? exp1.size() : exp2.size();
          checks++;
          if (n == 0) begin
            errors++;
            $display("FAIL sb_extra: master %0d got resp %b, none due",
                     m, s_resp[m*2 +: 2]);
          end else begin
            if (m == 0)      e = exp0.pop_front();
            else if (m == 1) e = exp1.pop_front();
            else             e = exp2.pop_front();
            if (s_resp[m*2 +: 2] !== e) begin
              errors++;
              $display("FAIL sb_resp: master %0d got %b want %b",
                       m, s_resp[m*2 +: 2], e);
            end
          end
        end
      end
    end
  end

  task automatic push_sq(input int s, input logic [1:0] bid,
                         input logic [1:0] resp);
    item_t it;
    it.bid  = bid;
    it.resp = resp;
    if (s == 0) sq0.push_back(it);
    else        sq1.push_back(it);
    if (bid == 2'd0)      exp0.push_back(resp);
    else if (bid == 2'd1) exp1.push_back(resp);
    else if (bid == 2'd2) exp2.push_back(resp);
  endtask

  task automatic aw_pulse(input logic [2:0] v);
    @(posedge clk);
    #1 aw = v;
    @(posedge clk);
    #1 aw = '0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    bit ok;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ok = (sq0.size() == 0) && (sq1.size() == 0) &&
           (m_valid == 2'b00) && (s_valid == 3'b000);
    end while (!ok && n < budget);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles", nm, n);
    end
  endtask

  task automatic wait_sv(input int m, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_valid[m] && n < budget);
    checks++;
    if (!s_valid[m]) begin
      errors++;
      $display("FAIL wait_bvalid%0d: bvalid=%b want 1", m, s_valid);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sq0.delete();
    sq1.delete();
    exp0.delete();
    exp1.delete();
    exp2.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_s.delete();
    got_m.delete();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_ready = 3'b111;
    aw      = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_ready, s_valid, s_resp} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs: ready=%b bvalid=%b bresp=%b want 0",
               m_ready, s_valid, s_resp);
    end
    checks++;
    if ({oz, e_bad, e_unx, e_ovf} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_flags: oz=%b err=%b%b%b want 111 000",
               oz, e_bad, e_unx, e_ovf);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    aw_pulse(3'b001);
    push_sq(0, 2'd0, 2'b00);
    @(negedge clk);
    checks++;
    if (m_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_bready: got %b want 01", m_ready);
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 3'b001 || s_resp[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL single_bvalid: bvalid=%b bresp=%b want 001/00",
               s_valid, s_resp[1:0]);
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 3'b000) begin
      errors++;
      $display("FAIL single_idle: bvalid=%b want 000", s_valid);
    end
    wait_idle("single", 20);
  endtask

  task automatic test_rr();
    int ws[6];
    int wm[6];
    ws = '{0, 1, 0, 1, 0, 1};
    wm = '{1, 0, 1, 0, 1, 2};
    do_reset();
    aw_pulse(3'b111);
    aw_pulse(3'b011);
    aw_pulse(3'b010);
    push_sq(0, 2'd1, 2'b01);
    push_sq(1, 2'd0, 2'b10);
    push_sq(0, 2'd1, 2'b00);
    push_sq(1, 2'd0, 2'b01);
    push_sq(0, 2'd1, 2'b11);
    push_sq(1, 2'd2, 2'b00);
    wait_idle("rr", 40);
    checks++;
    if (got_s.size() != 6 || got_m.size() != 6) begin
      errors++;
      $display("FAIL rr_count: grants=%0d delivered=%0d want 6/6",
               got_s.size(), got_m.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_s[i] != ws[i] || got_m[i] != wm[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: slave %0d master %0d want %0d %0d",
                   i, got_s[i], got_m[i], ws[i], wm[i]);
        end
      end
    end
    checks++;
    if (e_unx !== 1'b0 || oz !== 3'b111) begin
      errors++;
      $display("FAIL rr_ost: unexpected=%b oz=%b want 0/111", e_unx, oz);
    end
  endtask

  task automatic test_stall();
    s_ready[1] = 1'b0;
    aw_pulse(3'b011);
    push_sq(0, 2'd1, 2'b11);
    wait_sv(1, 20);
    push_sq(1, 2'd0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (s_valid !== 3'b010 || s_resp[3:2] !== 2'b11 ||
          m_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall[%0d]: bvalid=%b bresp=%b ready=%b",
                 i, s_valid, s_resp[3:2], m_ready);
      end
    end
    @(posedge clk);
    #1 s_ready[1] = 1'b1;
    wait_idle("stall", 20);
  endtask

  task automatic test_bad_bid();
    push_sq(0, 2'd3, 2'b10);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (e_bad !== 1'b1 || s_valid !== 3'b000) begin
      errors++;
      $display("FAIL bad_bid_pulse: err=%b bvalid=%b want 1/000",
               e_bad, s_valid);
    end
    @(negedge clk);
    checks++;
    if (e_bad !== 1'b0 || s_valid !== 3'b000) begin
      errors++;
      $display("FAIL bad_bid_end: err=%b bvalid=%b want 0/000",
               e_bad, s_valid);
    end
    wait_idle("bad_bid", 20);
  endtask

  task automatic test_outstanding();
    do_reset();
    repeat (3) aw_pulse(3'b001);
    @(negedge clk);
    checks++;
    if (oz[0] !== 1'b0) begin
      errors++;
      $display("FAIL ost_busy: oz0=%b want 0", oz[0]);
    end
    for (int i = 0; i < 3; i++) begin
      push_sq(0, 2'd0, 2'b00);
      wait_idle("ost", 20);
      checks++;
      if (oz[0] !== (i == 2)) begin
        errors++;
        $display("FAIL ost_zero[%0d]: oz0=%b want %0d", i, oz[0], i == 2);
      end
    end
    checks++;
    if (e_unx !== 1'b0) begin
      errors++;
      $display("FAIL ost_unx_early: got %b want 0", e_unx);
    end
    push_sq(1, 2'd0, 2'b01);
    wait_idle("unexp", 20);
    checks++;
    if (e_unx !== 1'b1 || oz[0] !== 1'b1) begin
      errors++;
      $display("FAIL ost_unexpected: err=%b oz0=%b want 1/1", e_unx, oz[0]);
    end
    for (int i = 0; i < 16; i++) begin
      aw_pulse(3'b010);
      if (i == 14) begin
        @(negedge clk);
        checks++;
        if (e_ovf !== 1'b0 || oz[1] !== 1'b0) begin
          errors++;
          $display("FAIL ost_full: ovf=%b oz1=%b want 0/0", e_ovf, oz[1]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (e_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ost_overflow: got %b want 1", e_ovf);
    end
  endtask

  task automatic test_reset_mid();
    s_ready[0] = 1'b0;
    aw_pulse(3'b001);
    push_sq(1, 2'd0, 2'b01);
    wait_sv(0, 20);
    exp0.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_valid !== 3'b000 || m_ready !== 2'b00 || oz !== 3'b111 ||
        e_ovf !== 1'b0 || e_unx !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: bvalid=%b ready=%b oz=%b ovf=%b unx=%b",
               s_valid, m_ready, oz, e_ovf, e_unx);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    s_ready = 3'b111;
    got_s.delete();
    got_m.delete();
    aw_pulse(3'b001);
    aw_pulse(3'b001);
    push_sq(0, 2'd0, 2'b10);
    push_sq(1, 2'd0, 2'b11);
    wait_idle("post_reset", 30);
    checks++;
    if (got_s.size() != 2 || got_s[0] != 0) begin
      errors++;
      $display("FAIL reset_first_grant: n=%0d first=%0d want 2/0",
               got_s.size(), got_s.size() > 0 ? got_s[0] : -1);
    end
    checks++;
    if (e_unx !== 1'b0 || oz !== 3'b111) begin
      errors++;
      $display("FAIL reset_ost: unx=%b oz=%b want 0/111", e_unx, oz);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    s_ready = 3'b111;
    aw      = '0;
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_bad_bid();
    test_outstanding();
    test_reset_mid();
    checks++;
    if (exp0.size() + exp1.size() + exp2.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d responses never delivered",
               exp0.size() + exp1.size() + exp2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
